trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap-entry/return sequencer for the machine-mode CSR bank. It arbitrates exception requests from the pipeline (memory access error, divide-by-zero, ebreak) under fixed priority. It then writes mepc, mcause, mtval and mipd through a single CSR write port, one register per cycle, and redirects the PC to the mtvec handler. On mret it sets mipd and returns the PC to mepc.

## Interface
Parameters:
- NUM_SRC, 3, number of trap sources; index 0 has the highest priority.
- XLEN, 32, data width.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- trap_req  in  NUM_SRC  per-source level request; the source holds it until acked.
- trap_val  in  NUM_SRC*XLEN  per-source trap value; slice i belongs to source i.
- trap_pc  in  XLEN  PC of the instruction at commit.
- trap_ack  out  NUM_SRC  one-hot, one-cycle accept pulse.
- mtvec_q  in  XLEN  current mtvec (0x305).
- mepc_q  in  XLEN  current mepc (0x341).
- mret  in  1  one-cycle return request.
- csr_we  out  1  CSR write strobe.
- csr_addr  out  12  CSR write address.
- csr_wdata  out  XLEN  CSR write data.
- pc_redirect  out  1  one-cycle PC load.
- pc_target  out  XLEN  PC load value.
- stall  out  1  freezes the pipeline.
- in_trap  out  1  high while the handler runs.

## Operation
- States and transitions:
  - IDLE → W_MEPC → W_MCAUSE → [W_MTVAL] → W_MIPD → REDIRECT → HANDLER → RET → IDLE.
- IDLE:
  - If any trap_req bit is high, the priority encoder picks the lowest set index.
  - The block latches the source, trap_pc and that source's trap_val slice.
  - trap_ack[src] pulses, stall=1, and the next state is W_MEPC.
  - mret in IDLE is ignored.
- W_MEPC: csr_we=1, addr 0x341, data = latched pc.
- W_MCAUSE: addr 0x342, data = CAUSE[src], zero-extended.
- W_MTVAL: addr 0x343, data = latched val.
- W_MIPD: addr 0x100, data 0.
- REDIRECT: pc_redirect=1, pc_target = {mtvec_q[XLEN-1:2], 2'b00}.
- HANDLER:
  - in_trap=1 and stall=0.
  - trap_req is not acked here; requests wait until the block is back in IDLE, so there is no nesting.
  - mret → RET. mret has priority over simultaneous trap_req.
- RET:
  - csr_we=1, addr 0x100, data 1.
  - pc_redirect=1, pc_target = mepc_q, stall=1.
  - Next state is IDLE.
- trap_req is sampled only in IDLE. A request dropped before its ack is lost without side effects.
- Reset mid-sequence:
  - Next cycle the block is in IDLE and all latches are cleared.
  - CSRs already written keep their values; the CSR bank has its own reset.

## Timing
- Reset values: every output is 0; state is IDLE.
- Trap entry:
  - The capture cycle is T.
  - CSR writes occur at T+1 through T+4 (T+1 through T+3 without mtval).
  - pc_redirect occurs at T+5 (T+4 without mtval).
  - stall is high from T through the REDIRECT cycle inclusive.
- Return: mret sampled in HANDLER at cycle R gives the RET outputs at R+1 and IDLE at R+2.
- Back-to-back: a request already pending at R+2 is captured at R+2.
- csr_we is never high in IDLE, REDIRECT or HANDLER.

## Configuration
- TRAP_CTRL_MTVAL_EN defined: the W_MTVAL state exists and trap_val is latched.
- Undefined:
  - W_MCAUSE goes directly to W_MIPD.
  - trap_val is unused and mtval is never written.
  - Entry latency drops by one cycle.

## Structure
- Package trap_ctrl_pkg holds:
  - state enum;
  - CSR address constants: MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343, MIPD 0x100;
  - CAUSE table: src0 mem error = 3, src1 div0 = 2, src2 ebreak = 1.
- Sub-module trap_prio_enc: combinational fixed-priority encoder producing a valid flag, a one-hot grant and an index.

## Test plan
- Single trap, all with TRAP_CTRL_MTVAL_EN:
  - Stimulus: trap_req=3'b100, trap_pc=0x0000_0040, val2=0x0010_0073, mtvec_q=0x0000_1003.
  - Required: ack=3'b100 at T; writes 0x341←0x40, 0x342←1, 0x343←0x00100073, 0x100←0; redirect to 0x1000 at T+5.
- Priority:
  - Stimulus: trap_req=3'b111.
  - Required: ack=3'b001, mcause=3. After mret, the remaining request 3'b110 gives ack=3'b010, mcause=2.
- Return:
  - Stimulus: mret in HANDLER with mepc_q=0x44.
  - Required: next cycle 0x100←1, pc_target=0x44, pc_redirect=1; IDLE the cycle after.
- Blocking in handler:
  - Stimulus: trap_req=3'b010 asserted during HANDLER, no mret for 10 cycles.
  - Required: no ack, csr_we stays 0.
- Reset mid-sequence:
  - Stimulus: rst high during W_MCAUSE.
  - Required: next cycle all outputs 0, state IDLE, no redirect.
- Macro off:
  - Required: same stimulus as the single-trap case gives three writes with no 0x343 write, and redirect at T+4.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states,
// CSR write addresses and the per-source cause table.
package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MEPC,
    ST_W_MCAUSE,
    ST_W_MTVAL,
    ST_W_MIPD,
    ST_REDIRECT,
    ST_HANDLER,
    ST_RET
  } state_e;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;
  localparam logic [11:0] CSR_MIPD   = 12'h100;

  localparam logic [3:0] CAUSE_MEM_ERR = 4'd3;
  localparam logic [3:0] CAUSE_DIV0    = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd1;

  // Source index to mcause code; unlisted sources report cause 0.
  function automatic logic [3:0] cause_code(input logic [7:0] src);
    case (src)
      8'd0:    cause_code = CAUSE_MEM_ERR;
      8'd1:    cause_code = CAUSE_DIV0;
      8'd2:    cause_code = CAUSE_EBREAK;
      default: cause_code = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Fixed-priority request encoder: the lowest set index wins and is
// reported as a valid flag, a one-hot grant and a binary index.
module trap_prio_enc
  import trap_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // Scanning downwards lets the lowest set index overwrite any higher one.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid    = 1'b1;
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap-entry/return sequencer: writes mepc/mcause/[mtval]/mipd one per cycle,
// redirects to mtvec and returns to mepc on mret. Macro TRAP_CTRL_MTVAL_EN adds the mtval write.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      trap_req,
  input  logic [NUM_SRC*XLEN-1:0] trap_val,
  input  logic [XLEN-1:0]         trap_pc,
  output logic [NUM_SRC-1:0]      trap_ack,
  input  logic [XLEN-1:0]         mtvec_q,
  input  logic [XLEN-1:0]         mepc_q,
  input  logic                    mret,
  output logic                    csr_we,
  output logic [11:0]             csr_addr,
  output logic [XLEN-1:0]         csr_wdata,
  output logic                    pc_redirect,
  output logic [XLEN-1:0]         pc_target,
  output logic                    stall,
  output logic                    in_trap
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [XLEN-1:0]    pc_q, pc_d;

  logic               req_valid;
  logic [NUM_SRC-1:0] req_grant;
  logic [IDX_W-1:0]   req_idx;

  trap_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .req   (trap_req),
    .valid (req_valid),
    .grant (req_grant),
    .idx   (req_idx)
  );

`ifdef TRAP_CTRL_MTVAL_EN
  logic [XLEN-1:0] val_q, val_d;
  logic [XLEN-1:0] val_sel;

  always_comb begin
    val_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_grant[i]) val_sel = trap_val[i*XLEN +: XLEN];
    end
  end

  logic unused_ok;
  assign unused_ok = ^mtvec_q[1:0];
`else
  logic unused_ok;
  assign unused_ok = ^{mtvec_q[1:0], trap_val};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      pc_q    <= '0;
`ifdef TRAP_CTRL_MTVAL_EN
      val_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      pc_q    <= pc_d;
`ifdef TRAP_CTRL_MTVAL_EN
      val_q   <= val_d;
`endif
    end
  end

  // Capture is suppressed during reset so no ack escapes in the reset cycle.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    pc_d        = pc_q;
`ifdef TRAP_CTRL_MTVAL_EN
    val_d       = val_q;
`endif
    trap_ack    = '0;
    csr_we      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    stall       = 1'b0;
    in_trap     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && !rst) begin
          trap_ack = req_grant;
          stall    = 1'b1;
          src_d    = req_idx;
          pc_d     = trap_pc;
`ifdef TRAP_CTRL_MTVAL_EN
          val_d    = val_sel;
`endif
          state_d  = ST_W_MEPC;
        end
      end
      ST_W_MEPC: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = pc_q;
        stall     = 1'b1;
        state_d   = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = {{(XLEN-4){1'b0}}, cause_code(8'(src_q))};
        stall     = 1'b1;
`ifdef TRAP_CTRL_MTVAL_EN
        state_d   = ST_W_MTVAL;
`else
        state_d   = ST_W_MIPD;
`endif
      end
`ifdef TRAP_CTRL_MTVAL_EN
      ST_W_MTVAL: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MTVAL;
        csr_wdata = val_q;
        stall     = 1'b1;
        state_d   = ST_W_MIPD;
      end
`endif
      ST_W_MIPD: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MIPD;
        csr_wdata = '0;
        stall     = 1'b1;
        state_d   = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        pc_redirect = 1'b1;
        pc_target   = {mtvec_q[XLEN-1:2], 2'b00};
        stall       = 1'b1;
        state_d     = ST_HANDLER;
      end
      ST_HANDLER: begin
        in_trap = 1'b1;
        if (mret) state_d = ST_RET;
      end
      ST_RET: begin
        csr_we      = 1'b1;
        csr_addr    = CSR_MIPD;
        csr_wdata   = XLEN'(1);
        pc_redirect = 1'b1;
        pc_target   = mepc_q;
        stall       = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level reference model.
module tb_trap_ctrl;

  localparam int K_WRITE = 0;
  localparam int K_REDIR = 1;
  localparam int K_RET   = 2;

`ifdef TRAP_CTRL_MTVAL_EN
  localparam int ENTRY_LAT = 5;
`else
  localparam int ENTRY_LAT = 4;
`endif

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  trap_req;
  logic [95:0] trap_val;
  logic [31:0] trap_pc;
  logic [2:0]  trap_ack;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic        mret;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        stall;
  logic        in_trap;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  int   ack_cyc = -1000;
  int   redir_cyc = 0;
  logic [2:0] req_hold = 3'b000;
  bit   rand_mode = 1'b0;

  rec_t exp_q[$];
  bit   in_handler = 1'b0;
  int   cause_tbl[3] = '{3, 2, 1};

  trap_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .trap_req    (trap_req),
    .trap_val    (trap_val),
    .trap_pc     (trap_pc),
    .trap_ack    (trap_ack),
    .mtvec_q     (mtvec_q),
    .mepc_q      (mepc_q),
    .mret        (mret),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .stall       (stall),
    .in_trap     (in_trap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: a trap is a list of pending cycle records drained one per cycle.
  task automatic modelStep();
    logic [2:0]  e_ack, onehot;
    logic        e_we, e_redir, e_stall, e_in_trap;
    logic [11:0] e_addr;
    logic [31:0] e_data, e_target;
    rec_t        rec;
    int          src;
    e_ack = '0; e_we = 0; e_redir = 0; e_stall = 0; e_in_trap = 0;
    e_addr = '0; e_data = '0; e_target = '0; src = 0;

    if (trap_ack != 3'b000) ack_cyc = cyc;
    if (pc_redirect && !csr_we) redir_cyc = cyc;

    if (rst) begin
      exp_q.delete();
      in_handler = 1'b0;
      return;
    end

    if (exp_q.size() != 0) begin
      rec = exp_q.pop_front();
      e_stall = 1'b1;
      if (rec.kind == K_REDIR) begin
        e_redir    = 1'b1;
        e_target   = {mtvec_q[31:2], 2'b00};
        in_handler = 1'b1;
      end else begin
        e_we   = 1'b1;
        e_addr = rec.addr;
        e_data = rec.data;
        if (rec.kind == K_RET) begin
          e_redir  = 1'b1;
          e_target = mepc_q;
        end
      end
    end else if (in_handler) begin
      e_in_trap = 1'b1;
      if (mret) begin
        exp_q.push_back('{K_RET, 12'h100, 32'd1});
        in_handler = 1'b0;
      end
    end else if (trap_req != 3'b000) begin
      onehot = trap_req & (~trap_req + 3'd1);
      case (onehot)
        3'b001:  src = 0;
        3'b010:  src = 1;
        default: src = 2;
      endcase
      e_ack   = onehot;
      e_stall = 1'b1;
      exp_q.push_back('{K_WRITE, 12'h341, trap_pc});
      exp_q.push_back('{K_WRITE, 12'h342, 32'(cause_tbl[src])});
`ifdef TRAP_CTRL_MTVAL_EN
      exp_q.push_back('{K_WRITE, 12'h343, trap_val[src*32 +: 32]});
`endif
      exp_q.push_back('{K_WRITE, 12'h100, 32'd0});
      exp_q.push_back('{K_REDIR, 12'h000, 32'd0});
    end

    checkOutput("trap_ack", 32'(trap_ack), 32'(e_ack));
    checkOutput("csr_we", 32'(csr_we), 32'(e_we));
    checkOutput("pc_redirect", 32'(pc_redirect), 32'(e_redir));
    checkOutput("stall", 32'(stall), 32'(e_stall));
    checkOutput("in_trap", 32'(in_trap), 32'(e_in_trap));
    if (e_we) begin
      checkOutput("csr_addr", 32'(csr_addr), 32'(e_addr));
      checkOutput("csr_wdata", csr_wdata, e_data);
    end
    if (e_redir) checkOutput("pc_target", pc_target, e_target);
    req_hold = req_hold & ~e_ack;
  endtask

  task automatic applyStimulus(input logic r, input logic m);
    @(negedge clk);
    rst      = r;
    mret     = m;
    trap_req = req_hold;
    if (rand_mode) begin
      trap_pc  = $urandom;
      trap_val = {$urandom, $urandom, $urandom};
      mtvec_q  = $urandom;
      mepc_q   = $urandom;
    end
    #2;
    cyc++;
    modelStep();
    if (r) req_hold = '0;
  endtask

  initial begin
    rst = 1'b1; mret = 1'b0; trap_req = '0;
    trap_val = '0; trap_pc = '0; mtvec_q = '0; mepc_q = '0;

    repeat (3) applyStimulus(1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0);

    $display("[TB] single trap from source 2");
    trap_pc  = 32'h0000_0040;
    trap_val = {32'h0010_0073, 32'h0, 32'h0};
    mtvec_q  = 32'h0000_1003;
    mepc_q   = 32'h0000_0000;
    req_hold = 3'b100;
    repeat (6) applyStimulus(1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0);
    checkOutput("entry_latency", 32'(redir_cyc - ack_cyc), 32'(ENTRY_LAT));
    checkOutput("handler_target", pc_target, 32'h0);

    $display("[TB] return via mret");
    mepc_q = 32'h0000_0044;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("ret_target", pc_target, 32'h0000_0044);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] priority and blocking in handler");
    req_hold = 3'b111;
    repeat (6) applyStimulus(1'b0, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0);
    checkOutput("pending_after_block", 32'(req_hold), 32'h6);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("second_src_ack", 32'(trap_ack), 32'h2);
    repeat (20) applyStimulus(1'b0, 1'b1);

    $display("[TB] reset during mcause write");
    applyStimulus(1'b1, 1'b0);
    req_hold = 3'b001;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_reset_redirect", 32'(pc_redirect), 32'h0);
    checkOutput("post_reset_we", 32'(csr_we), 32'h0);

    $display("[TB] random traffic");
    rand_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 3; b++) begin
        if (!req_hold[b] && $urandom_range(0, 5) == 0) req_hold[b] = 1'b1;
        else if (req_hold[b] && $urandom_range(0, 39) == 0) req_hold[b] = 1'b0;
      end
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
